// File: rtl/debouncer_mc.sv
// Multi-channel button debouncer: 2-flop synchronizer, stability counter,
// registered rise/fall edge pulses and a one-shot long-press pulse per channel.
module debouncer_mc #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 20
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_CH-1:0] but_i,
    output logic [N_CH-1:0] but_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] held_o
);

    localparam int unsigned CW = $clog2(STABLE_CYC);
    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_PRE    = HW'(HOLD_CYC - 1);

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    logic [CW-1:0] stab_cnt [N_CH];
    logic [CW-1:0] stab_nxt [N_CH];
    logic [HW-1:0] hold_cnt [N_CH];
    logic [HW-1:0] hold_nxt [N_CH];

    logic [N_CH-1:0] but_nxt;
    logic [N_CH-1:0] rise_nxt;
    logic [N_CH-1:0] fall_nxt;
    logic [N_CH-1:0] held_nxt;

    // Next-state: accept a new level only after it persists STABLE_CYC cycles.
    always_comb begin
        but_nxt  = but_o;
        rise_nxt = '0;
        fall_nxt = '0;
        held_nxt = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            stab_nxt[k] = stab_cnt[k];
            hold_nxt[k] = hold_cnt[k];

            if (sync2[k] == but_o[k]) begin
                stab_nxt[k] = '0;
            end else if (stab_cnt[k] == STABLE_LAST) begin
                stab_nxt[k] = '0;
                but_nxt[k]  = sync2[k];
                rise_nxt[k] = sync2[k];
                fall_nxt[k] = ~sync2[k];
            end else begin
                stab_nxt[k] = stab_cnt[k] + CW'(1);
            end

            // Long-press counter saturates so held fires once per accepted press.
            if (!but_o[k]) begin
                hold_nxt[k] = '0;
            end else if (hold_cnt[k] != HOLD_MAX) begin
                hold_nxt[k] = hold_cnt[k] + HW'(1);
                held_nxt[k] = (hold_cnt[k] == HOLD_PRE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1  <= '0;
            sync2  <= '0;
            but_o  <= '0;
            rise_o <= '0;
            fall_o <= '0;
            held_o <= '0;
            for (int k = 0; k < int'(N_CH); k++) begin
                stab_cnt[k] <= '0;
                hold_cnt[k] <= '0;
            end
        end else begin
            sync1  <= but_i;
            sync2  <= sync1;
            but_o  <= but_nxt;
            rise_o <= rise_nxt;
            fall_o <= fall_nxt;
            held_o <= held_nxt;
            for (int k = 0; k < int'(N_CH); k++) begin
                stab_cnt[k] <= stab_nxt[k];
                hold_cnt[k] <= hold_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_debouncer_mc.sv
// Scoreboard bench for debouncer_mc: driver feeds a window-based reference
// model that queues expected outputs; a monitor compares after every edge.
module tb_debouncer_mc;

    localparam int N      = 4;
    localparam int STABLE = 4;
    localparam int HOLD   = 20;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] held;
    } exp_t;

    logic         clk;
    logic         rstn;
    logic [N-1:0] but_i;
    logic [N-1:0] but_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic [N-1:0] held_o;

    int checks;
    int errors;
    int rise1_cnt;
    int held2_cnt;
    int fall2_cnt;

    exp_t exp_q[$];

    // Reference model state: raw sample pipeline, window of synchronized samples.
    logic [N-1:0] m_s1;
    logic [N-1:0] m_s2;
    logic [N-1:0] m_lvl;
    logic [N-1:0] m_hist[$];
    int           m_hold[N];

    debouncer_mc #(.N_CH(N), .STABLE_CYC(STABLE), .HOLD_CYC(HOLD)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .but_i  (but_i),
        .but_o  (but_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .held_o (held_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A level is accepted once the last STABLE synchronized samples all differ from it.
    task automatic model_edge(input logic [N-1:0] x, input logic r);
        exp_t         e;
        logic [N-1:0] new_lvl;
        bit           flip;
        e = '0;
        if (!r) begin
            m_s1  = '0;
            m_s2  = '0;
            m_lvl = '0;
            m_hist.delete();
            for (int c = 0; c < N; c++) m_hold[c] = 0;
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > STABLE) void'(m_hist.pop_front());
            new_lvl = m_lvl;
            for (int c = 0; c < N; c++) begin
                flip = (m_hist.size() == STABLE);
                foreach (m_hist[i]) if (m_hist[i][c] == m_lvl[c]) flip = 0;
                if (m_lvl[c]) begin
                    if (m_hold[c] < HOLD) begin
                        m_hold[c]++;
                        if (m_hold[c] == HOLD) e.held[c] = 1'b1;
                    end
                end else begin
                    m_hold[c] = 0;
                end
                if (flip) begin
                    new_lvl[c] = ~m_lvl[c];
                    e.rise[c]  = ~m_lvl[c];
                    e.fall[c]  = m_lvl[c];
                end
            end
            m_s2  = m_s1;
            m_s1  = x;
            m_lvl = new_lvl;
        end
        e.lvl = m_lvl;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] x, input logic r);
        @(negedge clk);
        but_i = x;
        rstn  = r;
        model_edge(x, r);
    endtask

    task automatic repeat_step(input logic [N-1:0] x, input logic r, input int n);
        for (int i = 0; i < n; i++) step(x, r);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: every edge yields an output vector, compare it with the queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{lvl: but_o, rise: rise_o, fall: fall_o, held: held_o};
                if (rise_o[1]) rise1_cnt++;
                if (held_o[2]) held2_cnt++;
                if (fall_o[2]) fall2_cnt++;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got but=%b rise=%b fall=%b held=%b expected but=%b rise=%b fall=%b held=%b",
                             $time, a.lvl, a.rise, a.fall, a.held, e.lvl, e.rise, e.fall, e.held);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int           rem[N];
        logic [N-1:0] cur;
        logic [N-1:0] v;
        rstn  = 1'b0;
        but_i = '0;
        checks = 0;
        errors = 0;
        rise1_cnt = 0;
        held2_cnt = 0;
        fall2_cnt = 0;

        // Long reset with all buttons released.
        repeat_step(4'b0000, 1'b0, 50);

        // Channel 0 toggles every 10 cycles.
        for (int t = 0; t < 6; t++) repeat_step((t % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1, 10);
        repeat_step(4'b0000, 1'b1, 10);

        // Channel 1: 3-cycle glitch must be rejected.
        settle();
        rise1_cnt = 0;
        repeat_step(4'b0010, 1'b1, 3);
        repeat_step(4'b0000, 1'b1, 12);
        settle();
        check_int("glitch_rise1", rise1_cnt, 0);

        // Channel 2: long press of 40 cycles, then release.
        held2_cnt = 0;
        fall2_cnt = 0;
        repeat_step(4'b0100, 1'b1, 40);
        repeat_step(4'b0000, 1'b1, 12);
        settle();
        check_int("long_press_held2", held2_cnt, 1);
        check_int("long_press_fall2", fall2_cnt, 1);

        // Channel 3: reset mid-hold, button kept pressed through and after reset.
        repeat_step(4'b1000, 1'b1, 6 + 10);
        repeat_step(4'b1000, 1'b0, 1);
        repeat_step(4'b1000, 1'b1, 12);
        repeat_step(4'b0000, 1'b1, 12);

        // All channels change together.
        repeat_step(4'b1111, 1'b1, 10);
        repeat_step(4'b0000, 1'b1, 10);

        // Button pressed throughout reset.
        repeat_step(4'b0101, 1'b0, 5);
        repeat_step(4'b0101, 1'b1, 10);
        repeat_step(4'b0000, 1'b1, 10);

        // Randomized runs: mostly clean presses, some glitches, rare resets.
        cur = '0;
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 10);
        for (int i = 0; i < 1500; i++) begin
            v = cur;
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    v[c]   = ~v[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30);
                end
                rem[c]--;
            end
            cur = v;
            step(cur, ($urandom_range(0, 299) != 0));
        end
        repeat_step(4'b0000, 1'b1, 10);

        settle();
        settle();
        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer_mc.md
DEBOUNCER_MC -- requirements
Module: debouncer_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (>=1).
REQ-002 SHALL have parameter STABLE_CYC, default 4: number of consecutive synchronized cycles a changed level must persist before it is accepted (>=2).
REQ-003 SHALL have parameter HOLD_CYC, default 20: cycles of accepted-high level before the long-press pulse fires (>STABLE_CYC).
REQ-004 SHALL have port clk  input  1: single clock for all logic; all state updates on the rising edge.
REQ-005 SHALL have port rstn  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port but_i  input  N_CH: raw asynchronous button levels, bit k = channel k.
REQ-007 SHALL have port but_o  output  N_CH: debounced level per channel.
REQ-008 SHALL have port rise_o  output  N_CH: one-cycle pulse when but_o[k] goes 0->1.
REQ-009 SHALL have port fall_o  output  N_CH: one-cycle pulse when but_o[k] goes 1->0.
REQ-010 SHALL have port held_o  output  N_CH: one-cycle pulse when but_o[k] has been 1 for HOLD_CYC cycles.

Function
REQ-011 SHALL pass each but_i[k] through a 2-flop synchronizer (sync1, sync2); sync2 is the only value used downstream.
REQ-012 SHALL keep per channel a stability counter, width clog2(STABLE_CYC), that resets to 0 any cycle sync2 == but_o.
REQ-013 SHALL increment the stability counter each cycle sync2 != but_o and its value < STABLE_CYC-1.
REQ-014 SHALL, in a cycle where sync2 != but_o and counter == STABLE_CYC-1, load but_o <= sync2 and clear the counter.
REQ-015 SHALL give latency: a clean level change on but_i[k] held steady appears on but_o[k] exactly STABLE_CYC+2 rising edges after it is first sampled.
REQ-016 SHALL ignore any input pulse or glitch whose synchronized width is < STABLE_CYC cycles; but_o unchanged, no pulses.
REQ-017 SHALL assert rise_o[k] (resp. fall_o[k]) for exactly the one cycle following the edge that sets (resp. clears) but_o[k]; registered, never both in one cycle.
REQ-018 SHALL keep per channel a hold counter, width clog2(HOLD_CYC+1), cleared whenever but_o[k] == 0, incremented while but_o[k] == 1, saturating at HOLD_CYC.
REQ-019 SHALL pulse held_o[k] for one cycle when the hold counter transitions to HOLD_CYC; no further pulse until but_o[k] returns to 0 and is accepted high again.
REQ-020 SHALL operate all channels fully independently; simultaneous events on several channels produce simultaneous, independent outputs.
REQ-021 SHALL treat a release accepted before HOLD_CYC as a short press: fall_o pulses, held_o never fires.

Reset
REQ-022 SHALL, on any rising edge with rstn == 0, clear sync1, sync2, all counters, but_o, rise_o, fall_o, held_o to 0.
REQ-023 SHALL apply reset identically mid-debounce or mid-hold; counting restarts from 0 after rstn returns high, no pulse is emitted for the aborted event.
REQ-024 SHALL, with but_i[k] = 1 throughout reset, raise but_o[k] and pulse rise_o[k] STABLE_CYC+2 edges after the first edge with rstn == 1.

Verification (N_CH=4, STABLE_CYC=4, HOLD_CYC=20, 10 ns clock)
REQ-025 SHALL cover: rstn=0 for 50 cycles with but_i=4'b0000 -> all outputs 0 throughout.
REQ-026 SHALL cover: but_i[0] toggles every 10 cycles after reset -> but_o[0] follows with 6-cycle lag, rise_o[0]/fall_o[0] alternate single-cycle pulses, held_o[0] stays 0.
REQ-027 SHALL cover: but_i[1] glitch high for 3 cycles -> but_o[1], rise_o[1] stay 0.
REQ-028 SHALL cover: but_i[2] held high 40 cycles -> rise_o[2] at edge 6, held_o[2] single pulse 20 cycles later, fall_o[2] 6 cycles after release.
REQ-029 SHALL cover: rstn pulled low while but_o[3]=1 and hold counter at 10 -> next edge all channel-3 outputs 0, no fall_o or held_o pulse.
REQ-030 SHALL cover: all four channels change together -> four identical, simultaneous rise_o bits at edge 6.
